// File: rtl/rv32_mem_arbiter.sv
// Purpose: shares one single-port unified memory between the fetch port and the load/store port.
// Latency: request sampled in IDLE, mem_req the next cycle, ack one cycle after mem_ready (3 cycles minimum).
// Backpressure: requesters hold req until ack; memory stalls with mem_ready low, bounded by a watchdog.
module rv32_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DATA_PRIO   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  // instruction fetch port
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  output logic            if_err,
  // load/store port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            d_err,
  // unified memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  // Last BUSY count before the watchdog fires: the TIMEOUT_CYC-th stalled cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  // Port owning the current transaction; doubles as the round-robin history.
  logic          last_grant;
  logic          grant_d;

  // Pick the winner among the requests present this cycle (only used in IDLE).
  always_comb begin
    grant_d = GNT_IF;
    if (d_req && !if_req) begin
      grant_d = GNT_D;
    end else if (d_req && if_req) begin
      if (DATA_PRIO != 0) begin
        grant_d = GNT_D;
      end else begin
        grant_d = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
      end
    end
  end

  // Transaction sequencer: grant, hold the memory request, watchdog, one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= GNT_IF;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      if_rdata   <= '0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      d_rdata    <= '0;
    end else begin
      // Acks and errors are single-cycle pulses; only the BUSY exit raises them.
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (if_req || d_req) begin
            mem_req    <= 1'b1;
            cnt        <= '0;
            last_grant <= grant_d;
            state      <= S_BUSY;
            if (grant_d == GNT_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // Loads read the full word; byte enables only qualify stores.
              mem_be    <= d_we ? d_be : {BW{1'b1}};
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_be    <= {BW{1'b1}};
            end
          end
        end

        S_BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_RESP;
            if (last_grant == GNT_D) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            // Memory hung: abandon the access and answer with an error.
            cnt     <= cnt + 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= S_RESP;
            if (last_grant == GNT_D) begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
            end else begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
              if_err   <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Requests are not sampled here, so a held req waits for IDLE.
        S_RESP: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Bench for rv32_mem_arbiter: two instances (data priority with short watchdog,
// round-robin with default watchdog) driven by a scripted memory responder.
// Expected transactions are queued as stimulus is driven and compared at each ack.
module tb_rv32_mem_arbiter;

  logic clk;
  logic reset;

  logic [1:0]  if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [3:0]  d_be [2];
  logic [31:0] mem_rdata [2];

  wire [1:0]  if_ack, if_err, d_ack, d_err, mem_req, mem_we;
  wire [31:0] if_rdata [2];
  wire [31:0] d_rdata [2];
  wire [31:0] mem_addr [2];
  wire [31:0] mem_wdata [2];
  wire [3:0]  mem_be [2];

  // Instance 0: data wins ties, watchdog at 8. Instance 1: round-robin, watchdog at 255.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv32_mem_arbiter #(
      .AW(32), .DW(32),
      .DATA_PRIO(g == 0 ? 1 : 0),
      .TIMEOUT_CYC(g == 0 ? 8 : 255)
    ) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
      .if_ack(if_ack[g]), .if_err(if_err[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
      .d_be(d_be[g]), .d_rdata(d_rdata[g]), .d_ack(d_ack[g]), .d_err(d_err[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_be(mem_be[g]), .mem_rdata(mem_rdata[g]),
      .mem_ready(mem_ready[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          port;   // 0 fetch, 1 data
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int rdy_dly [2];   // BUSY cycles before mem_ready; negative = never
  bit spur [2];      // drive mem_ready while no request is outstanding
  int wcnt [2];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_C3C3);
  endfunction

  function automatic exp_t mk(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata, input bit err);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
    e.be = be; e.rdata = rdata; e.err = err;
    return e;
  endfunction

  // Memory model: counts BUSY cycles and answers after rdy_dly of them.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if (mem_req[g] === 1'b1) begin
          mem_ready[g] = (rdy_dly[g] >= 0) && (wcnt[g] == rdy_dly[g]);
          mem_rdata[g] = mem_ready[g] ? memfn(mem_addr[g]) : 32'hBAD0_BAD0;
          wcnt[g]      = wcnt[g] + 1;
        end else begin
          mem_ready[g] = spur[g];
          mem_rdata[g] = 32'h1234_5678;
          wcnt[g]      = 0;
        end
      end
    end
  end

  // Requesters must hold req until ack (the bench's own protocol guard).
  logic [1:0] if_wait, d_wait;
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!reset && if_wait[g])
        assert (if_req[g] || if_ack[g]) else $error("if_req dropped before if_ack, inst %0d", g);
      if (!reset && d_wait[g])
        assert (d_req[g] || d_ack[g]) else $error("d_req dropped before d_ack, inst %0d", g);
      if_wait[g] <= if_req[g] && !if_ack[g] && !reset;
      d_wait[g]  <= d_req[g] && !d_ack[g] && !reset;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      n_tests++;
      if ({mem_req[g], mem_we[g], if_ack[g], d_ack[g], if_err[g], d_err[g]} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl inst%0d: got %b want 000000", g,
                 {mem_req[g], mem_we[g], if_ack[g], d_ack[g], if_err[g], d_err[g]});
      end
      n_tests++;
      if ({mem_addr[g], mem_wdata[g], mem_be[g]} !== 68'h0) begin
        n_fail++;
        $display("FAIL reset_mem inst%0d: got addr=%h wdata=%h be=%b want zeros",
                 g, mem_addr[g], mem_wdata[g], mem_be[g]);
      end
      n_tests++;
      if ({if_rdata[g], d_rdata[g]} !== 64'h0) begin
        n_fail++;
        $display("FAIL reset_rdata inst%0d: got if=%h d=%h want zeros", g, if_rdata[g], d_rdata[g]);
      end
    end
    reset = 1'b0;
  endtask

  // mem_ready with no outstanding request must not start or finish anything.
  task automatic test_idle_ready();
    @(negedge clk);
    spur[0] = 1'b1;
    spur[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_req, if_ack, d_ack} !== 6'b0) begin
        n_fail++;
        $display("FAIL idle_ready cyc%0d: got req=%b if_ack=%b d_ack=%b want all 0",
                 c, mem_req, if_ack, d_ack);
      end
    end
    spur[0] = 1'b0;
    spur[1] = 1'b0;
  endtask

  task automatic test_fetch_only();
    exp_t e;
    @(negedge clk);
    rdy_dly[0] = 0;
    if_addr[0] = 32'h100;
    if_req[0]  = 1'b1;
    sbq.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0050_0093, 1'b0));
    @(negedge clk);
    n_tests++;
    if ({mem_req[0], if_ack[0], mem_we[0], mem_addr[0], mem_be[0]} !==
        {1'b1, 1'b0, sbq[0].we, sbq[0].addr, sbq[0].be}) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b ack=%b we=%b addr=%h be=%b want req=1 ack=0 we=0 addr=100 be=1111",
               mem_req[0], if_ack[0], mem_we[0], mem_addr[0], mem_be[0]);
    end
    @(negedge clk);
    e = sbq.pop_front();
    n_tests++;
    if ({mem_req[0], if_ack[0], d_ack[0], if_err[0], if_rdata[0]} !== {4'b0100, e.rdata}) begin
      n_fail++;
      $display("FAIL fetch_ack: got req=%b if_ack=%b d_ack=%b err=%b rdata=%h want 0 1 0 0 %h",
               mem_req[0], if_ack[0], d_ack[0], if_err[0], if_rdata[0], e.rdata);
    end
    if_req[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_ack[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_ack_pulse: got if_ack=%b want 0", if_ack[0]);
    end
  endtask

  task automatic test_tie_data_prio();
    exp_t e;
    int got = 0;
    @(negedge clk);
    rdy_dly[0] = 0;
    if_addr[0] = 32'h200;
    if_req[0]  = 1'b1;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h2000;
    d_wdata[0] = 32'hDEAD_BEEF;
    d_be[0]    = 4'b0011;
    d_req[0]   = 1'b1;
    sbq.push_back(mk(1'b1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0));
    sbq.push_back(mk(1'b0, 1'b0, 32'h200, 32'h0, 4'hF, memfn(32'h200), 1'b0));
    for (int c = 0; c < 60 && got < 2; c++) begin
      @(negedge clk);
      if (mem_req[0]) begin
        n_tests++;
        if (sbq.size() == 0 ||
            {mem_we[0], mem_addr[0], mem_be[0]} !== {sbq[0].we, sbq[0].addr, sbq[0].be} ||
            (sbq[0].we && mem_wdata[0] !== sbq[0].wdata)) begin
          n_fail++;
          $display("FAIL tie_mem: got we=%b addr=%h wdata=%h be=%b, queued=%0d",
                   mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0], sbq.size());
        end
      end
      if (if_ack[0] || d_ack[0]) begin
        got++;
        n_tests++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL tie_ack: unexpected ack if=%b d=%b", if_ack[0], d_ack[0]);
        end else begin
          e = sbq.pop_front();
          if ({d_ack[0], if_ack[0]} !== (e.port ? 2'b10 : 2'b01) ||
              (e.port ? d_err[0] : if_err[0]) !== e.err ||
              (!e.we && (e.port ? d_rdata[0] : if_rdata[0]) !== e.rdata)) begin
            n_fail++;
            $display("FAIL tie_ack #%0d: got d_ack=%b if_ack=%b if_rdata=%h want port=%0d rdata=%h",
                     got, d_ack[0], if_ack[0], if_rdata[0], e.port, e.rdata);
          end
          if (e.port) d_req[0] = 1'b0;
          else        if_req[0] = 1'b0;
        end
      end
    end
    if (got < 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL tie_timeout: got %0d acks want 2", got);
      if_req[0] = 1'b0;
      d_req[0]  = 1'b0;
      sbq.delete();
    end
  endtask

  task automatic test_wait_states();
    exp_t e;
    int got = 0, busy = 0, rdy_c = -10;
    @(negedge clk);
    rdy_dly[0] = 5;
    d_we[0]    = 1'b1;
    d_addr[0]  = 32'h2400;
    d_wdata[0] = 32'hCAFE_F00D;
    d_be[0]    = 4'b1100;
    d_req[0]   = 1'b1;
    sbq.push_back(mk(1'b1, 1'b1, 32'h2400, 32'hCAFE_F00D, 4'b1100, 32'h0, 1'b0));
    for (int c = 0; c < 60 && got < 1; c++) begin
      @(negedge clk);
      if (mem_req[0]) begin
        busy++;
        if (mem_ready[0]) rdy_c = c;
        n_tests++;
        if (sbq.size() == 0 ||
            {mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]} !==
            {sbq[0].we, sbq[0].addr, sbq[0].wdata, sbq[0].be}) begin
          n_fail++;
          $display("FAIL wait_stable cyc%0d: got we=%b addr=%h wdata=%h be=%b want 1 2400 cafef00d 1100",
                   c, mem_we[0], mem_addr[0], mem_wdata[0], mem_be[0]);
        end
      end
      if (if_ack[0] || d_ack[0]) begin
        got++;
        e = sbq.pop_front();
        n_tests++;
        if ({d_ack[0], if_ack[0], d_err[0]} !== 3'b100 || busy != 6 || c != rdy_c + 1) begin
          n_fail++;
          $display("FAIL wait_ack: got d_ack=%b if_ack=%b err=%b busy=%0d lag=%0d want 1 0 0 busy=6 lag=1",
                   d_ack[0], if_ack[0], d_err[0], busy, c - rdy_c);
        end
        d_req[0] = 1'b0;
      end
    end
    if (got < 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_timeout: no ack within bound");
      d_req[0] = 1'b0;
      sbq.delete();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int got = 0, busy = 0;
    @(negedge clk);
    rdy_dly[0] = -1;
    d_we[0]    = 1'b0;
    d_addr[0]  = 32'h3000;
    d_be[0]    = 4'b0011;
    d_req[0]   = 1'b1;
    sbq.push_back(mk(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 32'h0, 1'b1));
    for (int c = 0; c < 80 && got < 2; c++) begin
      @(negedge clk);
      if (mem_req[0]) begin
        busy++;
        n_tests++;
        if (sbq.size() == 0 ||
            {mem_we[0], mem_addr[0], mem_be[0]} !== {sbq[0].we, sbq[0].addr, sbq[0].be}) begin
          n_fail++;
          $display("FAIL timeout_mem: got we=%b addr=%h be=%b, queued=%0d",
                   mem_we[0], mem_addr[0], mem_be[0], sbq.size());
        end
      end
      if (if_ack[0] || d_ack[0]) begin
        got++;
        e = sbq.pop_front();
        n_tests++;
        if ({d_ack[0], if_ack[0]} !== (e.port ? 2'b10 : 2'b01) ||
            (e.port ? d_err[0] : if_err[0]) !== e.err ||
            (e.port ? d_rdata[0] : if_rdata[0]) !== e.rdata ||
            (got == 1 && busy != 8)) begin
          n_fail++;
          $display("FAIL timeout_ack #%0d: got d_ack=%b d_err=%b d_rdata=%h if_ack=%b if_err=%b if_rdata=%h busy=%0d want port=%0d err=%0d rdata=%h busy=8",
                   got, d_ack[0], d_err[0], d_rdata[0], if_ack[0], if_err[0], if_rdata[0],
                   busy, e.port, e.err, e.rdata);
        end
        if (e.port) d_req[0] = 1'b0;
        else        if_req[0] = 1'b0;
        if (got == 1) begin
          // Follow-up fetch must be serviced normally after the error.
          rdy_dly[0] = 0;
          if_addr[0] = 32'h400;
          if_req[0]  = 1'b1;
          sbq.push_back(mk(1'b0, 1'b0, 32'h400, 32'h0, 4'hF, memfn(32'h400), 1'b0));
        end
      end
    end
    if (got < 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_bound: got %0d acks want 2", got);
      if_req[0] = 1'b0;
      d_req[0]  = 1'b0;
      sbq.delete();
    end
  endtask

  // A lone load leaves last_grant=D, so the held tie then alternates IF,D,IF,D.
  task automatic test_round_robin();
    exp_t e;
    int got = 0, if_left = 0, d_left = 0;
    @(negedge clk);
    rdy_dly[1] = 1;
    d_we[1]    = 1'b0;
    d_addr[1]  = 32'h5000;
    d_be[1]    = 4'b0101;
    d_req[1]   = 1'b1;
    sbq.push_back(mk(1'b1, 1'b0, 32'h5000, 32'h0, 4'hF, memfn(32'h5000), 1'b0));
    for (int c = 0; c < 100 && got < 5; c++) begin
      @(negedge clk);
      if (mem_req[1]) begin
        n_tests++;
        if (sbq.size() == 0 ||
            {mem_we[1], mem_addr[1], mem_be[1]} !== {sbq[0].we, sbq[0].addr, sbq[0].be}) begin
          n_fail++;
          $display("FAIL rr_mem: got we=%b addr=%h be=%b, queued=%0d",
                   mem_we[1], mem_addr[1], mem_be[1], sbq.size());
        end
      end
      if (if_ack[1] || d_ack[1]) begin
        got++;
        e = sbq.pop_front();
        n_tests++;
        if ({d_ack[1], if_ack[1]} !== (e.port ? 2'b10 : 2'b01) ||
            (e.port ? d_err[1] : if_err[1]) !== 1'b0 ||
            (e.port ? d_rdata[1] : if_rdata[1]) !== e.rdata) begin
          n_fail++;
          $display("FAIL rr_ack #%0d: got d_ack=%b if_ack=%b d_rdata=%h if_rdata=%h want port=%0d rdata=%h",
                   got, d_ack[1], if_ack[1], d_rdata[1], if_rdata[1], e.port, e.rdata);
        end
        if (got == 1) begin
          if_addr[1] = 32'h600;
          if_req[1]  = 1'b1;
          d_addr[1]  = 32'h5100;
          if_left    = 2;
          d_left     = 2;
          sbq.push_back(mk(1'b0, 1'b0, 32'h600,  32'h0, 4'hF, memfn(32'h600),  1'b0));
          sbq.push_back(mk(1'b1, 1'b0, 32'h5100, 32'h0, 4'hF, memfn(32'h5100), 1'b0));
          sbq.push_back(mk(1'b0, 1'b0, 32'h604,  32'h0, 4'hF, memfn(32'h604),  1'b0));
          sbq.push_back(mk(1'b1, 1'b0, 32'h5104, 32'h0, 4'hF, memfn(32'h5104), 1'b0));
        end else if (if_ack[1]) begin
          if_left--;
          if (if_left > 0) if_addr[1] = 32'h604;
          else             if_req[1]  = 1'b0;
        end else begin
          d_left--;
          if (d_left > 0) d_addr[1] = 32'h5104;
          else            d_req[1]  = 1'b0;
        end
      end
    end
    if (got < 5) begin
      n_tests++;
      n_fail++;
      $display("FAIL rr_bound: got %0d acks want 5", got);
      if_req[1] = 1'b0;
      d_req[1]  = 1'b0;
      sbq.delete();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int got = 0;
    @(negedge clk);
    rdy_dly[0] = -1;
    if_addr[0] = 32'h700;
    if_req[0]  = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (mem_req[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_busy: got mem_req=%b want 1", mem_req[0]);
    end
    reset     = 1'b1;
    if_req[0] = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_req[0], if_ack[0], d_ack[0], mem_addr[0], mem_be[0]} !== 39'h0) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got req=%b if_ack=%b d_ack=%b addr=%h be=%b want zeros",
               mem_req[0], if_ack[0], d_ack[0], mem_addr[0], mem_be[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({mem_req[0], if_ack[0], d_ack[0]} !== 3'b000) begin
        n_fail++;
        $display("FAIL rst_mid_noack cyc%0d: got req=%b if_ack=%b d_ack=%b want 000",
                 c, mem_req[0], if_ack[0], d_ack[0]);
      end
    end
    rdy_dly[0] = 0;
    if_addr[0] = 32'h100;
    if_req[0]  = 1'b1;
    sbq.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0050_0093, 1'b0));
    for (int c = 0; c < 40 && got < 1; c++) begin
      @(negedge clk);
      if (if_ack[0] || d_ack[0]) begin
        got++;
        e = sbq.pop_front();
        n_tests++;
        if ({if_ack[0], d_ack[0], if_err[0]} !== 3'b100 || if_rdata[0] !== e.rdata || c != 1) begin
          n_fail++;
          $display("FAIL rst_mid_fetch: got if_ack=%b d_ack=%b err=%b rdata=%h at cyc%0d want 1 0 0 %h at cyc1",
                   if_ack[0], d_ack[0], if_err[0], if_rdata[0], c, e.rdata);
        end
        if_req[0] = 1'b0;
      end
    end
    if (got < 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL rst_mid_bound: fetch after reset never acked");
      if_req[0] = 1'b0;
      sbq.delete();
    end
  endtask

  initial begin
    reset  = 1'b1;
    if_req = 2'b00;
    d_req  = 2'b00;
    d_we   = 2'b00;
    for (int g = 0; g < 2; g++) begin
      if_addr[g] = '0;
      d_addr[g]  = '0;
      d_wdata[g] = '0;
      d_be[g]    = '0;
      rdy_dly[g] = 0;
      spur[g]    = 1'b0;
      wcnt[g]    = 0;
    end
    test_reset();
    test_idle_ready();
    test_fetch_only();
    test_tie_data_prio();
    test_wait_states();
    test_timeout();
    test_round_robin();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
